// File: rtl/sal_frame_stats_if.sv
// Token stream bundle: DATA/SEND/COUNT travel downstream, ACK/RDY travel upstream.
// master = token producer, slave = token consumer (consumer answers with ACK only).
interface sal_frame_stats_if;
  localparam int unsigned DW = 16;

  logic [DW-1:0] DATA;
  logic          SEND;
  logic [DW-1:0] COUNT;
  logic          ACK;
  logic          RDY;

  modport master (output DATA, SEND, COUNT, input ACK, RDY);
  modport slave  (input DATA, SEND, COUNT, output ACK);
endinterface

// File: rtl/sal_frame_stats.sv
// Pixel passthrough FIFO (In1 -> Out1) with a per-frame maximum token on Out2.
// Define SAL_FRAME_STATS_MIN_EN to add a per-frame minimum token on Out3.
module sal_frame_stats #(
  parameter int unsigned FRAME_PIXELS = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  sal_frame_stats_if.slave  In1,
  sal_frame_stats_if.master Out1,
  sal_frame_stats_if.master Out2
`ifdef SAL_FRAME_STATS_MIN_EN
  ,
  sal_frame_stats_if.master Out3
`endif
);
  localparam int unsigned   DW       = 16;
  localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW       = AW + 1;
  localparam logic [DW-1:0] LAST_IDX = DW'(FRAME_PIXELS - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_EMIT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] pix_cnt_q, pix_cnt_d;
  logic [DW-1:0] run_max_q, run_max_d;
  logic [DW-1:0] max_lat_q, max_lat_d;
  logic [DW-1:0] hi_c;
  logic          push_c, pop_c, full_c, empty_c;
  logic          out2_send_c, emit_done_c;
`ifdef SAL_FRAME_STATS_MIN_EN
  logic [DW-1:0] run_min_q, run_min_d;
  logic [DW-1:0] min_lat_q, min_lat_d;
  logic [DW-1:0] lo_c;
  logic          out2_done_q, out2_done_d;
  logic          out3_done_q, out3_done_d;
  logic          out3_send_c;
`endif
  logic          unused_inputs;

  // Handshakes; a pop in the same cycle frees a slot for a push even when full.
  always_comb begin
    empty_c = (count_q == '0);
    full_c  = (count_q == CW'(FIFO_DEPTH));
    pop_c   = RESET && !empty_c && Out1.RDY;
    push_c  = RESET && In1.SEND && (state_q == ST_RUN) && (!full_c || pop_c);
    hi_c    = (In1.DATA > run_max_q) ? In1.DATA : run_max_q;
`ifdef SAL_FRAME_STATS_MIN_EN
    lo_c        = (In1.DATA < run_min_q) ? In1.DATA : run_min_q;
    out2_send_c = RESET && (state_q == ST_EMIT) && Out2.RDY && !out2_done_q;
    out3_send_c = RESET && (state_q == ST_EMIT) && Out3.RDY && !out3_done_q;
    emit_done_c = (out2_done_q || out2_send_c) && (out3_done_q || out3_send_c);
`else
    out2_send_c = RESET && (state_q == ST_EMIT) && Out2.RDY;
    emit_done_c = out2_send_c;
`endif
  end

  // Next state for FIFO, frame counter, statistics and RUN/EMIT control.
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pix_cnt_d = pix_cnt_q;
    run_max_d = run_max_q;
    max_lat_d = max_lat_q;
`ifdef SAL_FRAME_STATS_MIN_EN
    run_min_d   = run_min_q;
    min_lat_d   = min_lat_q;
    out2_done_d = out2_done_q || out2_send_c;
    out3_done_d = out3_done_q || out3_send_c;
`endif
    count_d = count_q + CW'(push_c) - CW'(pop_c);

    if (push_c) begin
      mem_d[wr_ptr_q] = In1.DATA;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      run_max_d       = hi_c;
`ifdef SAL_FRAME_STATS_MIN_EN
      run_min_d       = lo_c;
`endif
      if (pix_cnt_q == LAST_IDX) begin
        pix_cnt_d = '0;
        max_lat_d = hi_c;
`ifdef SAL_FRAME_STATS_MIN_EN
        min_lat_d = lo_c;
`endif
        state_d   = ST_EMIT;
      end else begin
        pix_cnt_d = pix_cnt_q + DW'(1);
      end
    end

    if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);

    // Leaving EMIT opens the next frame with cleared running statistics.
    if ((state_q == ST_EMIT) && emit_done_c) begin
      state_d   = ST_RUN;
      run_max_d = '0;
`ifdef SAL_FRAME_STATS_MIN_EN
      run_min_d   = '1;
      out2_done_d = 1'b0;
      out3_done_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
    if (!RESET) begin
      state_q   <= ST_RUN;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pix_cnt_q <= '0;
      run_max_q <= '0;
      max_lat_q <= '0;
`ifdef SAL_FRAME_STATS_MIN_EN
      run_min_q   <= '1;
      min_lat_q   <= '1;
      out2_done_q <= 1'b0;
      out3_done_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pix_cnt_q <= pix_cnt_d;
      run_max_q <= run_max_d;
      max_lat_q <= max_lat_d;
`ifdef SAL_FRAME_STATS_MIN_EN
      run_min_q   <= run_min_d;
      min_lat_q   <= min_lat_d;
      out2_done_q <= out2_done_d;
      out3_done_q <= out3_done_d;
`endif
    end
  end

  // Stream outputs are forced quiet while RESET is low.
  assign In1.ACK    = push_c;
  assign Out1.SEND  = pop_c;
  assign Out1.DATA  = pop_c ? mem_q[rd_ptr_q] : '0;
  assign Out1.COUNT = DW'(1);
  assign Out2.SEND  = out2_send_c;
  assign Out2.DATA  = (RESET && (state_q == ST_EMIT)) ? max_lat_q : '0;
  assign Out2.COUNT = DW'(1);
`ifdef SAL_FRAME_STATS_MIN_EN
  assign Out3.SEND  = out3_send_c;
  assign Out3.DATA  = (RESET && (state_q == ST_EMIT)) ? min_lat_q : '0;
  assign Out3.COUNT = DW'(1);
  assign unused_inputs = ^{In1.COUNT, Out1.ACK, Out2.ACK, Out3.ACK};
`else
  assign unused_inputs = ^{In1.COUNT, Out1.ACK, Out2.ACK};
`endif
endmodule

// File: tb/tb_sal_frame_stats.sv
// Bench for sal_frame_stats: directed scenarios plus a randomized multi-frame run,
// checked against per-frame max/min computed from the list of handshaken pixels.
module tb_sal_frame_stats;
  localparam int unsigned FP    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          TMO   = 200;

  typedef logic [15:0] wq_t [$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  wq_t  sent, got1, got2;
`ifdef SAL_FRAME_STATS_MIN_EN
  wq_t  got3;
`endif

  sal_frame_stats_if in1 ();
  sal_frame_stats_if out1 ();
  sal_frame_stats_if out2 ();
`ifdef SAL_FRAME_STATS_MIN_EN
  sal_frame_stats_if out3 ();
`endif

  sal_frame_stats #(.FRAME_PIXELS(FP), .FIFO_DEPTH(DEPTH)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .In1   (in1),
    .Out1  (out1),
    .Out2  (out2)
`ifdef SAL_FRAME_STATS_MIN_EN
    ,
    .Out3  (out3)
`endif
  );

  always #5 clk = ~clk;

  // Collect every transferred output token.
  always @(negedge clk) begin
    if (rst_n && out1.SEND === 1'b1) got1.push_back(out1.DATA);
    if (rst_n && out2.SEND === 1'b1) got2.push_back(out2.DATA);
`ifdef SAL_FRAME_STATS_MIN_EN
    if (rst_n && out3.SEND === 1'b1) got3.push_back(out3.DATA);
`endif
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic wq_t frame_max(input wq_t s);
    wq_t r;
    for (int f = 0; f + int'(FP) <= s.size(); f += int'(FP)) begin
      logic [15:0] m = 16'h0000;
      for (int i = 0; i < int'(FP); i++) if (s[f+i] > m) m = s[f+i];
      r.push_back(m);
    end
    return r;
  endfunction

  function automatic wq_t frame_min(input wq_t s);
    wq_t r;
    for (int f = 0; f + int'(FP) <= s.size(); f += int'(FP)) begin
      logic [15:0] m = 16'hFFFF;
      for (int i = 0; i < int'(FP); i++) if (s[f+i] < m) m = s[f+i];
      r.push_back(m);
    end
    return r;
  endfunction

  // Index of the first difference between two streams, -1 when identical.
  function automatic int q_diff(input wq_t a, input wq_t b);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic logic [15:0] q_at(input wq_t a, input int i);
    return (i >= 0 && i < a.size()) ? a[i] : 16'h0000;
  endfunction

  function automatic logic [15:0] rand_px();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic set_rdy(input logic r1, input logic r2);
    out1.RDY = r1;
    out2.RDY = r2;
`ifdef SAL_FRAME_STATS_MIN_EN
    out3.RDY = 1'b1;
`endif
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    in1.SEND = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sent.delete(); got1.delete(); got2.delete();
`ifdef SAL_FRAME_STATS_MIN_EN
    got3.delete();
`endif
  endtask

  // Offer one pixel and hold it until the handshake completes.
  task automatic send_px(input logic [15:0] d);
    int n = 0;
    in1.SEND = 1'b1;
    in1.DATA = d;
    @(negedge clk);
    while (in1.ACK !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      checks++; errors++;
      $display("FAIL send_timeout: pixel %h not acknowledged within %0d cycles", d, TMO);
    end else begin
      sent.push_back(d);
    end
    @(posedge clk);
    #1;
    in1.SEND = 1'b0;
  endtask

  task automatic test_reset();
    in1.SEND = 1'b1;
    in1.DATA = 16'h0007;
    set_rdy(1'b1, 1'b1);
    @(negedge clk);
    checks++; if (in1.ACK !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", in1.ACK); end
    checks++; if (out1.SEND !== 1'b0) begin errors++; $display("FAIL reset_out1_send: got %b want 0", out1.SEND); end
    checks++; if (out2.SEND !== 1'b0) begin errors++; $display("FAIL reset_out2_send: got %b want 0", out2.SEND); end
    checks++; if (out1.DATA !== 16'h0) begin errors++; $display("FAIL reset_out1_data: got %h want 0000", out1.DATA); end
    checks++; if (out2.DATA !== 16'h0) begin errors++; $display("FAIL reset_out2_data: got %h want 0000", out2.DATA); end
    checks++; if (out1.COUNT !== 16'h1) begin errors++; $display("FAIL out1_count: got %h want 0001", out1.COUNT); end
    checks++; if (out2.COUNT !== 16'h1) begin errors++; $display("FAIL out2_count: got %h want 0001", out2.COUNT); end
    in1.SEND = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (out1.SEND !== 1'b0) begin errors++; $display("FAIL post_reset_empty: out1 send got %b want 0", out1.SEND); end
    checks++; if (out2.SEND !== 1'b0) begin errors++; $display("FAIL post_reset_run: out2 send got %b want 0", out2.SEND); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int d;
    apply_reset();
    set_rdy(1'b1, 1'b1);
    send_px(16'd3); send_px(16'd9); send_px(16'd2); send_px(16'd7);
    in1.SEND = 1'b1;
    in1.DATA = 16'h0055;
    @(negedge clk);
    checks++; if (in1.ACK !== 1'b0) begin errors++; $display("FAIL basic_emit_ack: got %b want 0", in1.ACK); end
    checks++; if (out2.SEND !== 1'b1) begin errors++; $display("FAIL basic_out2_send: got %b want 1", out2.SEND); end
    checks++; if (out2.DATA !== 16'd9) begin errors++; $display("FAIL basic_out2_data: got %0d want 9", out2.DATA); end
    @(posedge clk);
    #1;
    in1.SEND = 1'b0;
    wait_cycles(4);
    checks++; d = q_diff(got1, sent);
    if (d >= 0) begin errors++; $display("FAIL basic_out1 item %0d: got %h (%0d items) want %h (%0d items)", d, q_at(got1, d), got1.size(), q_at(sent, d), sent.size()); end
    checks++; if (got2.size() != 1 || q_at(got2, 0) !== 16'd9) begin errors++; $display("FAIL basic_out2_stream: got %0d tokens first %0d want 1 token 9", got2.size(), q_at(got2, 0)); end
  endtask

  task automatic test_fifo_full();
    logic [15:0] toks [6];
    int nxt = 0;
    int d;
    apply_reset();
    set_rdy(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) toks[i] = 16'($urandom);
    for (int k = 0; k < 6; k++) begin
      in1.SEND = 1'b1;
      in1.DATA = toks[nxt];
      @(negedge clk);
      checks++;
      if (in1.ACK !== 1'(k < 4)) begin errors++; $display("FAIL full_ack cycle %0d: got %b want %b", k, in1.ACK, 1'(k < 4)); end
      if (in1.ACK === 1'b1) begin sent.push_back(toks[nxt]); nxt++; end
      @(posedge clk);
      #1;
    end
    out1.RDY = 1'b1;
    in1.DATA = toks[nxt];
    @(negedge clk);
    checks++; if (in1.ACK !== 1'b1) begin errors++; $display("FAIL full_push_pop_ack: got %b want 1", in1.ACK); end
    checks++; if (out1.SEND !== 1'b1) begin errors++; $display("FAIL full_push_pop_send: got %b want 1", out1.SEND); end
    if (in1.ACK === 1'b1) begin sent.push_back(toks[nxt]); nxt++; end
    @(posedge clk);
    #1;
    in1.SEND = 1'b0;
    while (nxt < 6) begin send_px(toks[nxt]); nxt++; end
    wait_cycles(8);
    checks++; d = q_diff(got1, sent);
    if (d >= 0 || got1.size() != 6) begin errors++; $display("FAIL full_out1 item %0d: got %h (%0d items) want %h (6 items)", d, q_at(got1, d), got1.size(), q_at(sent, d)); end
    checks++; d = q_diff(got2, frame_max(sent));
    if (d >= 0) begin errors++; $display("FAIL full_out2 item %0d: got %h (%0d tokens) want %h", d, q_at(got2, d), got2.size(), q_at(frame_max(sent), d)); end
  endtask

  task automatic test_emit_stall();
    int d;
    wq_t mx;
    apply_reset();
    set_rdy(1'b1, 1'b0);
    for (int i = 0; i < int'(FP); i++) send_px(rand_px());
    mx = frame_max(sent);
    in1.SEND = 1'b1;
    in1.DATA = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (in1.ACK !== 1'b0) begin errors++; $display("FAIL stall_ack cycle %0d: got %b want 0", k, in1.ACK); end
      checks++; if (out2.SEND !== 1'b0) begin errors++; $display("FAIL stall_out2 cycle %0d: got %b want 0", k, out2.SEND); end
      @(posedge clk);
      #1;
    end
    checks++; d = q_diff(got1, sent);
    if (d >= 0) begin errors++; $display("FAIL stall_drain item %0d: got %h (%0d items) want %h (%0d items)", d, q_at(got1, d), got1.size(), q_at(sent, d), sent.size()); end
    out2.RDY = 1'b1;
    @(negedge clk);
    checks++; if (out2.SEND !== 1'b1) begin errors++; $display("FAIL stall_release_send: got %b want 1", out2.SEND); end
    checks++; if (out2.DATA !== q_at(mx, 0)) begin errors++; $display("FAIL stall_release_data: got %h want %h", out2.DATA, q_at(mx, 0)); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (in1.ACK !== 1'b1) begin errors++; $display("FAIL stall_resume_ack: got %b want 1", in1.ACK); end
    if (in1.ACK === 1'b1) sent.push_back(16'h1234);
    @(posedge clk);
    #1;
    in1.SEND = 1'b0;
    wait_cycles(4);
    checks++; if (got2.size() != 1) begin errors++; $display("FAIL stall_out2_count: got %0d tokens want 1", got2.size()); end
  endtask

  task automatic test_reset_mid();
    int d;
    apply_reset();
    set_rdy(1'b0, 1'b1);
    send_px(16'hAAAA);
    send_px(16'hBBBB);
    apply_reset();
    set_rdy(1'b1, 1'b1);
    for (int i = 0; i < int'(FP); i++) send_px(16'd1);
    wait_cycles(6);
    checks++; d = q_diff(got1, sent);
    if (d >= 0) begin errors++; $display("FAIL midreset_out1 item %0d: got %h (%0d items) want %h (%0d items)", d, q_at(got1, d), got1.size(), q_at(sent, d), sent.size()); end
    checks++; if (got2.size() != 1 || q_at(got2, 0) !== 16'd1) begin errors++; $display("FAIL midreset_out2: got %0d tokens first %h want 1 token 0001", got2.size(), q_at(got2, 0)); end
    // Reset while a frame statistic is pending in EMIT.
    set_rdy(1'b1, 1'b0);
    for (int i = 0; i < int'(FP); i++) send_px(16'hC000 + 16'(i));
    wait_cycles(2);
    apply_reset();
    set_rdy(1'b1, 1'b1);
    wait_cycles(4);
    checks++; if (got2.size() != 0) begin errors++; $display("FAIL emitreset_out2: got %0d tokens want 0", got2.size()); end
    checks++; if (got1.size() != 0) begin errors++; $display("FAIL emitreset_out1: got %0d pixels want 0", got1.size()); end
    for (int i = 0; i < int'(FP); i++) send_px(16'd2);
    wait_cycles(6);
    checks++; d = q_diff(got2, frame_max(sent));
    if (d >= 0) begin errors++; $display("FAIL emitreset_next item %0d: got %h (%0d tokens) want 0002", d, q_at(got2, d), got2.size()); end
  endtask

  task automatic test_saturate();
    logic [15:0] px [12];
    int d;
    px = '{16'hFFFF, 16'h0, 16'h0, 16'h0, 16'd5, 16'd5, 16'd5, 16'd5, 16'h0, 16'h0, 16'h0, 16'h0};
    apply_reset();
    set_rdy(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) send_px(px[i]);
    wait_cycles(6);
    checks++; d = q_diff(got2, frame_max(sent));
    if (d >= 0) begin errors++; $display("FAIL sat_out2 item %0d: got %h (%0d tokens) want %h", d, q_at(got2, d), got2.size(), q_at(frame_max(sent), d)); end
    checks++; if (q_at(got2, 0) !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h want ffff", q_at(got2, 0)); end
    checks++; if (q_at(got2, 1) !== 16'd5) begin errors++; $display("FAIL sat_five: got %h want 0005", q_at(got2, 1)); end
    checks++; if (got2.size() != 3 || q_at(got2, 2) !== 16'h0) begin errors++; $display("FAIL sat_zero_frame: got %0d tokens last %h want 3 tokens last 0000", got2.size(), q_at(got2, 2)); end
    checks++; d = q_diff(got1, sent);
    if (d >= 0) begin errors++; $display("FAIL sat_out1 item %0d: got %h want %h", d, q_at(got1, d), q_at(sent, d)); end
  endtask

  task automatic test_random();
    int  d;
    bit  done = 1'b0;
    apply_reset();
    set_rdy(1'b1, 1'b1);
    fork
      begin
        for (int i = 0; i < 6 * int'(FP); i++) send_px(rand_px());
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out1.RDY = 1'($urandom_range(0, 1));
          out2.RDY = 1'($urandom_range(0, 1));
`ifdef SAL_FRAME_STATS_MIN_EN
          out3.RDY = 1'($urandom_range(0, 1));
`endif
        end
      end
    join
    set_rdy(1'b1, 1'b1);
    wait_cycles(10);
    checks++; d = q_diff(got1, sent);
    if (d >= 0) begin errors++; $display("FAIL rand_out1 item %0d: got %h (%0d items) want %h (%0d items)", d, q_at(got1, d), got1.size(), q_at(sent, d), sent.size()); end
    checks++; d = q_diff(got2, frame_max(sent));
    if (d >= 0) begin errors++; $display("FAIL rand_out2 item %0d: got %h (%0d tokens) want %h", d, q_at(got2, d), got2.size(), q_at(frame_max(sent), d)); end
`ifdef SAL_FRAME_STATS_MIN_EN
    checks++; d = q_diff(got3, frame_min(sent));
    if (d >= 0) begin errors++; $display("FAIL rand_out3 item %0d: got %h (%0d tokens) want %h", d, q_at(got3, d), got3.size(), q_at(frame_min(sent), d)); end
`endif
  endtask

`ifdef SAL_FRAME_STATS_MIN_EN
  task automatic test_min();
    apply_reset();
    set_rdy(1'b1, 1'b1);
    out3.RDY = 1'b0;
    send_px(16'd8); send_px(16'd3); send_px(16'd12); send_px(16'd4);
    in1.SEND = 1'b1;
    in1.DATA = 16'h0077;
    @(negedge clk);
    checks++; if (out2.SEND !== 1'b1 || out2.DATA !== 16'd12) begin errors++; $display("FAIL min_out2: send %b data %0d want send 1 data 12", out2.SEND, out2.DATA); end
    checks++; if (in1.ACK !== 1'b0) begin errors++; $display("FAIL min_ack_e0: got %b want 0", in1.ACK); end
    @(posedge clk);
    #1;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      checks++; if (in1.ACK !== 1'b0) begin errors++; $display("FAIL min_ack cycle %0d: got %b want 0", k, in1.ACK); end
      checks++; if (out2.SEND !== 1'b0) begin errors++; $display("FAIL min_out2_once cycle %0d: got %b want 0", k, out2.SEND); end
      @(posedge clk);
      #1;
    end
    out3.RDY = 1'b1;
    @(negedge clk);
    checks++; if (out3.SEND !== 1'b1 || out3.DATA !== 16'd3) begin errors++; $display("FAIL min_out3: send %b data %0d want send 1 data 3", out3.SEND, out3.DATA); end
    checks++; if (in1.ACK !== 1'b0) begin errors++; $display("FAIL min_ack_e3: got %b want 0", in1.ACK); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (in1.ACK !== 1'b1) begin errors++; $display("FAIL min_resume_ack: got %b want 1", in1.ACK); end
    @(posedge clk);
    #1;
    in1.SEND = 1'b0;
    wait_cycles(4);
    checks++; if (got2.size() != 1 || got3.size() != 1 || q_at(got3, 0) !== 16'd3) begin errors++; $display("FAIL min_streams: out2 %0d tokens, out3 %0d tokens first %0d; want 1, 1, 3", got2.size(), got3.size(), q_at(got3, 0)); end
  endtask
`endif

  initial begin
    in1.SEND  = 1'b0;
    in1.DATA  = 16'h0;
    in1.COUNT = 16'h1;
    in1.RDY   = 1'b0;
    out1.ACK  = 1'b0;
    out2.ACK  = 1'b0;
    out1.RDY  = 1'b0;
    out2.RDY  = 1'b0;
`ifdef SAL_FRAME_STATS_MIN_EN
    out3.ACK  = 1'b0;
    out3.RDY  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_fifo_full();
    test_emit_stall();
    test_reset_mid();
    test_saturate();
    test_random();
`ifdef SAL_FRAME_STATS_MIN_EN
    test_min();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
